writeback: RTL and testbench

WRITEBACK -- requirements
Module: writeback

---
 rtl/y86_pkg.sv | 33 +++
 rtl/y86_regfile.sv | 64 ++++++
 rtl/writeback.sv | 99 +++++++++
 tb/tb_writeback.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the writeback slice.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-to-read forwarding).
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RSP  = 4'h4;
    localparam logic [3:0] R_NONE = 4'hF;

    localparam int NREGS = 15;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } wb_state_t;

    // Codes above popq are not part of the instruction set.
    function automatic logic icode_ok(input logic [3:0] ic);
        return ic <= I_POPQ;
    endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x 64-bit, two write ports (M over E), two reads.
// Optional feature macro: WB_BYPASS_EN (reads see same-cycle write data).
module y86_regfile
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_e,
    input  logic [3:0]  dst_e,
    input  logic [63:0] val_e,
    input  logic        we_m,
    input  logic [3:0]  dst_m,
    input  logic [63:0] val_m,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] val_a,
    output logic [63:0] val_b
);

    logic [63:0] regs [NREGS];

    // Register update; the M write is issued last so it wins on a shared dst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we_e && dst_e != R_NONE) begin
                regs[dst_e] <= val_e;
            end
            if (we_m && dst_m != R_NONE) begin
                regs[dst_m] <= val_m;
            end
        end
    end

`ifdef WB_BYPASS_EN
    function automatic logic [63:0] rd(input logic [3:0] src);
        if (src == R_NONE)
            return '0;
        else if (we_m && src == dst_m)
            return val_m;
        else if (we_e && src == dst_e)
            return val_e;
        else
            return regs[src];
    endfunction
`else
    function automatic logic [63:0] rd(input logic [3:0] src);
        if (src == R_NONE)
            return '0;
        else
            return regs[src];
    endfunction
`endif

    // Combinational read ports; index F reads as zero.
    always_comb begin
        val_a = rd(src_a);
        val_b = rd(src_b);
    end

endmodule

// File: rtl/writeback.sv
// Y86-64 writeback stage: destination select, halt/error FSM, regfile.
// Optional feature macro: WB_BYPASS_EN (forward write data to valA/valB).
module writeback
    import y86_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [3:0]  srcA,
    input  logic [3:0]  srcB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic        halted,
    output logic        inst_err
);

    wb_state_t   state;
    logic        halted_q;
    logic        err_q;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        active;
    logic        we_e;
    logic        we_m;

    // Destination for the ALU result.
    always_comb begin
        dst_e = R_NONE;
        case (icode)
            I_CMOVXX: dst_e = cnd ? rB : R_NONE;
            I_IRMOVQ,
            I_OPQ:    dst_e = rB;
            I_CALL,
            I_RET,
            I_PUSHQ,
            I_POPQ:   dst_e = R_RSP;
            default:  dst_e = R_NONE;
        endcase
    end

    // Destination for the memory read data.
    always_comb begin
        dst_m = R_NONE;
        case (icode)
            I_MRMOVQ,
            I_POPQ:   dst_m = rA;
            default:  dst_m = R_NONE;
        endcase
    end

    // Writes happen only for a valid, legal instruction while running.
    always_comb begin
        active = wb_valid && state == ST_RUN && icode_ok(icode);
        we_e   = active && dst_e != R_NONE;
        we_m   = active && dst_m != R_NONE;
    end

    // Run/stop machine; stop is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (wb_valid && state == ST_RUN) begin
            if (icode == I_HALT) begin
                state    <= ST_STOP;
                halted_q <= 1'b1;
            end else if (!icode_ok(icode)) begin
                state <= ST_STOP;
                err_q <= 1'b1;
            end
        end
    end

    assign halted   = halted_q;
    assign inst_err = err_q;

    y86_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we_e  (we_e),
        .dst_e (dst_e),
        .val_e (valE),
        .we_m  (we_m),
        .dst_m (dst_m),
        .val_m (valM),
        .src_a (srcA),
        .src_b (srcB),
        .val_a (valA),
        .val_b (valB)
    );

endmodule

// File: tb/tb_writeback.sv
// Directed scoreboard bench for the writeback stage.
// Build with WB_BYPASS_EN defined to check same-cycle forwarding.
module tb_writeback;
    import y86_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [3:0]  icode = I_NOP;
    logic [3:0]  rA = R_NONE;
    logic [3:0]  rB = R_NONE;
    logic        cnd = 1'b0;
    logic [63:0] valE = '0;
    logic [63:0] valM = '0;
    logic [3:0]  srcA = R_NONE;
    logic [3:0]  srcB = R_NONE;
    logic [63:0] valA;
    logic [63:0] valB;
    logic        halted;
    logic        inst_err;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q [$];
    string       tag_q [$];

    writeback dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .icode    (icode),
        .rA       (rA),
        .rB       (rB),
        .cnd      (cnd),
        .valE     (valE),
        .valM     (valM),
        .srcA     (srcA),
        .srcB     (srcB),
        .valA     (valA),
        .valB     (valB),
        .halted   (halted),
        .inst_err (inst_err)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [63:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic chk(input logic [63:0] got);
        logic [63:0] exp;
        string       tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic rd_a(input string tag, input logic [3:0] r,
                        input logic [63:0] v);
        push(tag, v);
        srcA = r;
        #1;
        chk(valA);
    endtask

    task automatic rd_b(input string tag, input logic [3:0] r,
                        input logic [63:0] v);
        push(tag, v);
        srcB = r;
        #1;
        chk(valB);
    endtask

    task automatic flags(input string tag, input logic h, input logic e);
        push({tag, "_halted"}, {63'b0, h});
        chk({63'b0, halted});
        push({tag, "_err"}, {63'b0, e});
        chk({63'b0, inst_err});
    endtask

    task automatic wb(input logic [3:0] ic, input logic [3:0] ra,
                      input logic [3:0] rb, input logic c,
                      input logic [63:0] e, input logic [63:0] m);
        @(negedge clk);
        wb_valid = 1'b1;
        icode = ic;
        rA = ra;
        rB = rb;
        cnd = c;
        valE = e;
        valM = m;
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        icode = I_NOP;
    endtask

    task automatic idle(input logic [3:0] ic, input logic [3:0] rb,
                        input logic [63:0] e);
        @(negedge clk);
        wb_valid = 1'b0;
        icode = ic;
        rB = rb;
        valE = e;
        @(posedge clk);
        #1;
        icode = I_NOP;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        rd_a("rst_r0", 4'd0, 64'h0);
        rd_b("rst_r4", R_RSP, 64'h0);
        flags("rst", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // irmovq then read on the next cycle
        wb(I_IRMOVQ, R_NONE, 4'd3, 1'b0, 64'h1234, 64'h0);
        rd_a("irmovq_r3", 4'd3, 64'h1234);

        // cmovxx with condition false then true
        wb(I_CMOVXX, 4'd1, 4'd2, 1'b0, 64'd5, 64'h0);
        rd_a("cmov_nc_r2", 4'd2, 64'h0);
        wb(I_CMOVXX, 4'd1, 4'd2, 1'b1, 64'd5, 64'h0);
        rd_a("cmov_c_r2", 4'd2, 64'd5);

        // OPq result to rB
        wb(I_OPQ, 4'd1, 4'd7, 1'b0, 64'd99, 64'h0);
        rd_b("opq_r7", 4'd7, 64'd99);

        // popq %rsp: M port beats E port
        wb(I_POPQ, R_RSP, R_NONE, 1'b0, 64'h108, 64'hAA);
        rd_a("popq_rsp", R_RSP, 64'hAA);

        // popq to another register updates both
        wb(I_POPQ, 4'd5, R_NONE, 1'b0, 64'h200, 64'hBB);
        rd_a("popq2_rsp", R_RSP, 64'h200);
        rd_b("popq2_r5", 4'd5, 64'hBB);

        // mrmovq loads into rA, call updates %rsp
        wb(I_MRMOVQ, 4'd8, 4'd1, 1'b0, 64'h55, 64'hCAFE);
        rd_a("mrmovq_r8", 4'd8, 64'hCAFE);
        rd_b("mrmovq_r1", 4'd1, 64'h0);
        wb(I_CALL, R_NONE, R_NONE, 1'b0, 64'hF0, 64'h0);
        rd_a("call_rsp", R_RSP, 64'hF0);

        // wb_valid low: no write, no halt
        idle(I_IRMOVQ, 4'd9, 64'hDEAD);
        rd_a("idle_r9", 4'd9, 64'h0);
        idle(I_HALT, R_NONE, 64'h0);
        flags("idle_halt", 1'b0, 1'b0);

        // Index F reads zero
        rd_a("src_none", R_NONE, 64'h0);

        // Same-cycle read of a register being written
        @(negedge clk);
        wb_valid = 1'b1;
        icode = I_OPQ;
        rA = 4'd1;
        rB = 4'd6;
        valE = 64'd7;
`ifdef WB_BYPASS_EN
        rd_b("bypass_r6", 4'd6, 64'd7);
`else
        rd_b("nobypass_r6", 4'd6, 64'd0);
`endif
        @(posedge clk);
        #1;
        wb_valid = 1'b0;
        icode = I_NOP;
        rd_b("after_r6", 4'd6, 64'd7);

        // Halt blocks later writes
        wb(I_IRMOVQ, R_NONE, 4'd0, 1'b0, 64'h11, 64'h0);
        rd_a("pre_halt_r0", 4'd0, 64'h11);
        wb(I_HALT, R_NONE, R_NONE, 1'b0, 64'h0, 64'h0);
        flags("halt", 1'b1, 1'b0);
        wb(I_IRMOVQ, R_NONE, 4'd0, 1'b0, 64'h55, 64'h0);
        rd_a("halted_r0", 4'd0, 64'h11);
        flags("halt_hold", 1'b1, 1'b0);

        // Reset pulse leaves STOP
        #2;
        rst_n = 1'b0;
        #1;
        flags("halt_rst", 1'b0, 1'b0);
        rd_a("halt_rst_r0", 4'd0, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wb(I_IRMOVQ, R_NONE, 4'd3, 1'b0, 64'h1234, 64'h0);
        rd_a("rerun_r3", 4'd3, 64'h1234);

        // Invalid icode stops with error, no write
        wb(4'hC, 4'd3, 4'd3, 1'b1, 64'h77, 64'h88);
        flags("ierr", 1'b0, 1'b1);
        rd_a("ierr_r3", 4'd3, 64'h1234);
        wb(I_IRMOVQ, R_NONE, 4'd3, 1'b0, 64'h99, 64'h0);
        rd_a("ierr_hold_r3", 4'd3, 64'h1234);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        flags("arst", 1'b0, 1'b0);
        rd_a("arst_r3", 4'd3, 64'h0);
        rd_b("arst_rsp", R_RSP, 64'h0);

        // Write presented while in reset is discarded
        wb(I_IRMOVQ, R_NONE, 4'd3, 1'b0, 64'h999, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        rd_a("rst_drop_r3", 4'd3, 64'h0);
        wb(I_IRMOVQ, R_NONE, 4'd3, 1'b0, 64'h4242, 64'h0);
        rd_a("post_rst_r3", 4'd3, 64'h4242);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
